// File: rtl/riscv_pkg.sv
// Shared RV32 pipeline definitions: word width, bubble encoding and the IF/ID
// register layout used by both the fetch and decode stages.
package riscv_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;  // addi x0,x0,0
   localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
      logic            valid;
   } if_id_t;

   localparam if_id_t IF_ID_BUBBLE = '{pc: '0, instr: NOP_INSTR, valid: 1'b0};

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: instruction-memory port, pipeline control from later
// stages and the IF/ID outputs. master = the fetch unit, slave = its environment.
interface fetch_unit_if;
   import riscv_pkg::*;

   logic [XLEN-1:0] imem_addr;
   logic [XLEN-1:0] imem_instr;
   logic            stall;
   logic            flush;
   logic            redirect;
   logic [XLEN-1:0] redirect_target;
   logic [XLEN-1:0] if_id_pc;
   logic [XLEN-1:0] if_id_instr;
   logic            if_id_valid;
   logic [XLEN-1:0] fetch_count;

   modport master (
      output imem_addr, if_id_pc, if_id_instr, if_id_valid, fetch_count,
      input  imem_instr, stall, flush, redirect, redirect_target
   );

   modport slave (
      input  imem_addr, if_id_pc, if_id_instr, if_id_valid, fetch_count,
      output imem_instr, stall, flush, redirect, redirect_target
   );

endinterface

// File: rtl/fetch_unit_pc_register.sv
// Program counter with reset > redirect > stall > sequential-increment priority.
module pc_register
   import riscv_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            redirect,
   input  logic            stall,
   input  logic [XLEN-1:0] redirect_target,
   output logic [XLEN-1:0] pc
);

   logic [XLEN-1:0] pc_q, pc_d;

   always_comb begin
      // NOTE: pc_d is given its hold value before any branch, so every path
      // assigns it and no latch is inferred.
      pc_d = pc_q;
      if (redirect) begin
         pc_d = redirect_target & ~32'd3;   // targets are always word aligned
      end else if (!stall) begin
         pc_d = pc_q + 32'd4;               // natural wrap at 2^32
      end
   end

   // NOTE: sequential state uses non-blocking assignment so every flop samples
   // pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (reset) pc_q <= RESET_PC;
      else       pc_q <= pc_d;
   end

   assign pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: drives the PC to the combinational instruction memory
// and captures the returned word into the IF/ID register, inserting bubbles.
module fetch_unit
   import riscv_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
   input logic          clk,
   input logic          reset,
   fetch_unit_if.master bus
);

   logic [XLEN-1:0] pc;
   if_id_t          if_id_q, if_id_d;
   logic [XLEN-1:0] fetch_count_q, fetch_count_d;

   pc_register #(.RESET_PC(RESET_PC)) u_pc_register (
      .clk             (clk),
      .reset           (reset),
      .redirect        (bus.redirect),
      .stall           (bus.stall),
      .redirect_target (bus.redirect_target),
      .pc              (pc)
   );

   always_comb begin
      if_id_d       = if_id_q;
      fetch_count_d = fetch_count_q;
      if (bus.redirect || bus.flush) begin
         if_id_d = IF_ID_BUBBLE;
      end else if (!bus.stall) begin
         // A real capture: only this path counts toward fetch_count.
         if_id_d       = '{pc: pc, instr: bus.imem_instr, valid: 1'b1};
         fetch_count_d = fetch_count_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         if_id_q       <= IF_ID_BUBBLE;
         fetch_count_q <= '0;
      end else begin
         if_id_q       <= if_id_d;
         fetch_count_q <= fetch_count_d;
      end
   end

   assign bus.imem_addr   = pc;
   assign bus.if_id_pc    = if_id_q.pc;
   assign bus.if_id_instr = if_id_q.instr;
   assign bus.if_id_valid = if_id_q.valid;
   assign bus.fetch_count = fetch_count_q;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the 32-bit RISC-V pipeline. It owns the program counter, drives the fetch address into the combinational instruction memory and captures the returned instruction into the IF/ID pipeline register. It accepts stall, flush and branch-redirect requests from later stages and produces bubbles (canonical NOP, valid low) where required.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013: `addi x0,x0,0`, the instruction used for bubbles.

- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_addr  out  32  fetch address; equals the current PC register (combinational from the register).
- imem_instr  in  32  instruction returned by the instruction memory in the same cycle.
- stall  in  1  hold the PC and the IF/ID contents.
- flush  in  1  replace the IF/ID contents with a bubble.
- redirect  in  1  a taken branch or jump; load `redirect_target` into the PC.
- redirect_target  in  32  new PC; bits [1:0] ignored and forced to 0.
- if_id_pc  out  32  PC of the instruction held in IF/ID.
- if_id_instr  out  32  instruction held in IF/ID.
- if_id_valid  out  1  IF/ID holds a real instruction.
- fetch_count  out  32  number of instructions captured with valid=1; wraps.

## Operation
- PC next-state priority, highest first:
  - reset: PC = RESET_PC.
  - redirect: PC = {redirect_target[31:2],2'b00}.
  - stall: PC holds.
  - otherwise: PC + 4, modulo 2^32; 0xFFFF_FFFC wraps to 0x0000_0000.
- IF/ID next-state priority, highest first:
  - reset: pc=0, instr=NOP_INSTR, valid=0.
  - redirect or flush: bubble, i.e. pc=0, instr=NOP_INSTR, valid=0.
  - stall: hold all three fields.
  - otherwise: pc=PC, instr=imem_instr, valid=1.
- Combined inputs:
  - flush without redirect: the PC still advances, unless stall is also high, in which case the PC holds.
  - stall and flush together: IF/ID takes the bubble and the PC holds.
  - redirect beats stall on both the PC and IF/ID.
- fetch_count:
  - Increments by 1 on each edge where IF/ID loads with valid=1.
  - Resets to 0.
  - Wraps 0xFFFF_FFFF to 0.
- Address range: no check on the PC. The memory decodes addr[9:2] only, so aliasing beyond 1 KiB is the memory's behaviour, not an error here.
- Unknown imem_instr content is captured as-is. A zero word is passed through and is not converted to NOP.

## Timing
- Reset values: imem_addr=RESET_PC, if_id_pc=0, if_id_instr=NOP_INSTR, if_id_valid=0, fetch_count=0.
- First cycle after reset deasserts: imem_addr=RESET_PC. At the next edge IF/ID holds the instruction at RESET_PC with valid=1 (latency 1 cycle).
- Steady state: one instruction per cycle.
- Redirect asserted in cycle N:
  - The target appears on imem_addr in cycle N+1.
  - IF/ID shows a bubble in cycle N+1.
  - The target instruction appears in IF/ID in cycle N+2.
- Stall is level-sensitive: every stalled cycle holds its state. Releasing stall resumes fetch from the held PC with no lost or duplicated instruction.
- Reset asserted mid-operation overrides all inputs on that edge.

## Structure
- A shared package `riscv_pkg` holds:
  - XLEN=32.
  - the NOP_INSTR constant 32'h0000_0013.
  - the default RESET_PC.
  - an IF/ID struct type {pc, instr, valid}, reused by the decode stage.
- One sub-module, `pc_register`, is natural. It contains the PC flop with the reset/redirect/stall/increment priority. The IF/ID register and fetch_count stay in fetch_unit.

## Test plan
- Reset release, no stall/redirect, memory word 0 = 32'h0005_2083 and word 1 = 32'h0045_2103 -> IF/ID shows (0x0, 0x0005_2083, valid=1), then (0x4, 0x0045_2103, valid=1); fetch_count=2.
- stall held for 3 cycles with PC=0x8 -> imem_addr stays 0x8 and IF/ID is unchanged for 3 cycles; after release the next IF/ID pc is 0x8, with no skipped or repeated PC.
- redirect with target 0x0000_0023 while PC=0x10 -> next imem_addr=0x20; IF/ID bubble (NOP, valid=0) for one cycle; then IF/ID pc=0x20; fetch_count does not count the bubble.
- redirect and stall in the same cycle -> redirect wins: PC=target and IF/ID is a bubble.
- flush alone at PC=0xC -> IF/ID becomes a bubble and the PC advances to 0x10. stall+flush at PC=0xC -> bubble, and the PC holds at 0xC.
- RESET_PC=32'hFFFF_FFFC -> after reset the fetch sequence is 0xFFFF_FFFC then 0x0000_0000. Reset asserted mid-stream -> all outputs return to their reset values on the next edge.
